// File: rtl/usbf_icb_bridge_pkg.sv
// Shared definitions for the ICB-to-CSR bridge: state encodings, default window base, response entry layout.
package usbf_icb_bridge_pkg;

  typedef enum logic [0:0] {
    USBF_BRIDGE_IDLE = 1'b0,
    USBF_BRIDGE_BUSY = 1'b1
  } bridge_state_e;

  localparam logic [31:0] USBF_DEFAULT_BASE_ADDR = 32'h1000_0000;

  // Response entry is {err, rdata}
  localparam int unsigned RSP_ERR_W = 1;

  function automatic int unsigned rsp_entry_w(input int unsigned dw);
    return RSP_ERR_W + dw;
  endfunction

endpackage

// File: rtl/usbf_bridge_rsp_fifo.sv
// First-word fall-through response FIFO; data output reads as zero while empty.
module usbf_bridge_rsp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 33,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    do_pop   = pop_i & (count_q != '0);
    do_push  = push_i & ((count_q < CW'(DEPTH)) | do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/usbf_icb_bridge.sv
// ICB slave to CSR bridge with window decode, one access in flight and a buffered response path.
// Optional CSR ack timeout is enabled with `define USBF_BRIDGE_TIMEOUT_EN.
module usbf_icb_bridge
  import usbf_icb_bridge_pkg::*;
#(
  parameter int unsigned   AW        = 32,
  parameter int unsigned   DW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = AW'(USBF_DEFAULT_BASE_ADDR),
  parameter int unsigned   WIN_BITS  = 12,
  parameter int unsigned   RSP_DEPTH = 2,
  parameter int unsigned   TMO_W     = 8
) (
  input  logic            hclk_i,
  input  logic            hrst_i,
  input  logic            icb_cmd_valid_i,
  output logic            icb_cmd_ready_o,
  input  logic [AW-1:0]   icb_cmd_addr_i,
  input  logic            icb_cmd_read_i,
  input  logic [DW-1:0]   icb_cmd_wdata_i,
  input  logic [DW/8-1:0] icb_cmd_wmask_i,
  output logic            icb_rsp_valid_o,
  input  logic            icb_rsp_ready_i,
  output logic [DW-1:0]   icb_rsp_rdata_o,
  output logic            icb_rsp_err_o,
  output logic            csr_req_o,
  output logic            csr_we_o,
  output logic [AW-1:0]   csr_addr_o,
  output logic [DW-1:0]   csr_wdata_o,
  output logic [DW/8-1:0] csr_wmask_o,
  input  logic            csr_ack_i,
  input  logic [DW-1:0]   csr_rdata_i
);

  localparam int unsigned EW = rsp_entry_w(DW);
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned MW = DW / 8;

  if ((DW % 8) != 0 || RSP_DEPTH < 1 || TMO_W < 1 || WIN_BITS >= AW) begin : g_bad_cfg
    $error("usbf_icb_bridge: unsupported parameter set");
  end

  bridge_state_e   state_q, state_d;
  logic            req_q, req_d, we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]   wmask_q, wmask_d;
  logic            push;
  logic [EW-1:0]   push_data;
  logic [EW-1:0]   pop_data;
  logic [CW-1:0]   fifo_count;
  logic            cmd_fire, win_hit;
`ifdef USBF_BRIDGE_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  assign icb_cmd_ready_o = (state_q == USBF_BRIDGE_IDLE) && (fifo_count < CW'(RSP_DEPTH));
  assign cmd_fire        = icb_cmd_valid_i & icb_cmd_ready_o;
  assign win_hit         = (icb_cmd_addr_i[AW-1:WIN_BITS] == BASE_ADDR[AW-1:WIN_BITS]);

  // Next-state: accept/decode in IDLE, wait for ack (or timeout) in BUSY
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    push      = 1'b0;
    push_data = '0;
`ifdef USBF_BRIDGE_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    case (state_q)
      USBF_BRIDGE_IDLE: begin
        if (cmd_fire) begin
          if (win_hit) begin
            state_d = USBF_BRIDGE_BUSY;
            req_d   = 1'b1;
            we_d    = ~icb_cmd_read_i;
            addr_d  = icb_cmd_addr_i;
            wdata_d = icb_cmd_wdata_i;
            wmask_d = icb_cmd_read_i ? '0 : icb_cmd_wmask_i;
`ifdef USBF_BRIDGE_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end else begin
            push      = 1'b1;
            push_data = {1'b1, {DW{1'b0}}};
          end
        end
      end
      USBF_BRIDGE_BUSY: begin
        if (csr_ack_i) begin
          push      = 1'b1;
          push_data = {1'b0, (we_q ? {DW{1'b0}} : csr_rdata_i)};
          req_d     = 1'b0;
          state_d   = USBF_BRIDGE_IDLE;
`ifdef USBF_BRIDGE_TIMEOUT_EN
        end else if (tmo_q == {TMO_W{1'b1}}) begin
          push      = 1'b1;
          push_data = {1'b1, {DW{1'b0}}};
          req_d     = 1'b0;
          state_d   = USBF_BRIDGE_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
`endif
        end
      end
      default: state_d = USBF_BRIDGE_IDLE;
    endcase
  end

  always_ff @(posedge hclk_i) begin
    if (hrst_i) begin
      state_q <= USBF_BRIDGE_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
`ifdef USBF_BRIDGE_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
`ifdef USBF_BRIDGE_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  usbf_bridge_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (EW),
    .CW    (CW)
  ) u_rsp_fifo (
    .clk_i       (hclk_i),
    .rst_i       (hrst_i),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (icb_rsp_ready_i),
    .valid_o     (icb_rsp_valid_o),
    .data_o      (pop_data),
    .count_o     (fifo_count)
  );

  assign icb_rsp_err_o   = pop_data[EW-1];
  assign icb_rsp_rdata_o = pop_data[DW-1:0];
  assign csr_req_o       = req_q;
  assign csr_we_o        = we_q;
  assign csr_addr_o      = addr_q;
  assign csr_wdata_o     = wdata_q;
  assign csr_wmask_o     = wmask_q;

endmodule
